// File: rtl/reu_pkg.sv
// Transfer-type codes and sequencer state encoding for the REU transfer sequencer.
package reu_pkg;

   localparam logic [1:0] XT_STASH  = 2'b00;
   localparam logic [1:0] XT_FETCH  = 2'b01;
   localparam logic [1:0] XT_SWAP   = 2'b10;
   localparam logic [1:0] XT_VERIFY = 2'b11;

   typedef enum logic [3:0] {
      IDLE, ARM, SETUP, STASH, FETCH, SW_RD, SW_WR, VERIFY, END, ERR
   } reu_state_e;

   // First byte-cycle state entered after DMA setup for a given transfer type.
   function automatic reu_state_e byte_state(input logic [1:0] xfer_type);
      reu_state_e w_st;
      unique case (xfer_type)
         XT_STASH: w_st = STASH;
         XT_FETCH: w_st = FETCH;
         XT_SWAP:  w_st = SW_RD;
         default:  w_st = VERIFY;
      endcase
      return w_st;
   endfunction

endpackage

// File: rtl/reu_swap_latch.sv
// Holds the C64 and REU bytes read in the first half of a swap until they are
// written back crosswise; updates on the falling edge of PHI2.
module reu_swap_latch (
   input  logic       i_phi2,
   input  logic       i_reset,
   input  logic       i_load,
   input  logic [7:0] i_c64_din,
   input  logic [7:0] i_ram_din,
   output logic [7:0] o_lat_c,
   output logic [7:0] o_lat_r
);

   logic [7:0] r_lat_c;
   logic [7:0] r_lat_r;

   always_ff @(negedge i_phi2) begin
      if (i_reset) begin
         r_lat_c <= 8'h00;
         r_lat_r <= 8'h00;
      end else if (i_load) begin
         r_lat_c <= i_c64_din;
         r_lat_r <= i_ram_din;
      end
   end

   assign o_lat_c = r_lat_c;
   assign o_lat_r = r_lat_r;

endmodule

// File: rtl/reu_xfer_seq.sv
// REU DMA transfer sequencer: stash/fetch/swap/verify byte cycles on the PHI2 falling edge.
// Define REU_VERIFY_EN to build the verify comparator; otherwise verify is a read-only pass.
module reu_xfer_seq
   import reu_pkg::*;
#(
   parameter int unsigned DMA_SETUP = 1
) (
   input  logic       i_phi2,
   input  logic       i_reset,
   input  logic       i_execute,
   input  logic       i_ff00_decode,
   input  logic [1:0] i_xfer_type,
   input  logic       i_length1,
   input  logic       i_cpu_wr_ff00,
   input  logic       i_ba,
   input  logic [7:0] i_c64_din,
   input  logic [7:0] i_ram_din,
   output logic       o_dma,
   output logic       o_c64_rd,
   output logic       o_c64_wr,
   output logic       o_ram_rd,
   output logic       o_ram_wr,
   output logic [7:0] o_c64_dout,
   output logic [7:0] o_ram_dout,
   output logic       o_next_ca,
   output logic       o_next_reua,
   output logic       o_xfer_end,
   output logic       o_verify_err
);

   localparam logic [1:0] SETUP_LAST = 2'(DMA_SETUP - 1);

   reu_state_e r_state;
   logic [1:0] r_setup_cnt;
   logic       r_dma;
   logic       r_xfer_end;
   logic       w_mismatch;
   logic       w_next;
   logic       w_lat_load;
   logic [7:0] w_lat_c;
   logic [7:0] w_lat_r;

`ifdef REU_VERIFY_EN
   assign w_mismatch   = (i_c64_din != i_ram_din);
   assign o_verify_err = (r_state == ERR);
`else
   assign w_mismatch   = 1'b0;
   assign o_verify_err = 1'b0;
`endif

   always_ff @(negedge i_phi2) begin
      if (i_reset) begin
         r_state     <= IDLE;
         r_setup_cnt <= 2'd0;
         r_dma       <= 1'b0;
         r_xfer_end  <= 1'b0;
      end else begin
         r_xfer_end <= 1'b0;
         unique case (r_state)
            IDLE: begin
               r_setup_cnt <= 2'd0;
               if (i_execute) begin
                  if (i_ff00_decode) begin
                     r_state <= ARM;
                  end else begin
                     r_state <= SETUP;
                     r_dma   <= 1'b1;
                  end
               end
            end
            ARM: begin
               if (!i_execute) begin
                  r_state <= IDLE;
               end else if (i_cpu_wr_ff00) begin
                  r_state <= SETUP;
                  r_dma   <= 1'b1;
               end
            end
            SETUP: begin
               if (r_setup_cnt == SETUP_LAST) begin
                  r_state <= byte_state(i_xfer_type);
               end else begin
                  r_setup_cnt <= r_setup_cnt + 2'd1;
               end
            end
            STASH, FETCH: begin
               if (i_ba && i_length1) begin
                  r_state    <= END;
                  r_xfer_end <= 1'b1;
               end
            end
            SW_RD: begin
               if (i_ba) r_state <= SW_WR;
            end
            SW_WR: begin
               if (i_ba) begin
                  if (i_length1) begin
                     r_state    <= END;
                     r_xfer_end <= 1'b1;
                  end else begin
                     r_state <= SW_RD;
                  end
               end
            end
            VERIFY: begin
               // A mismatch on the last byte still reports ERR rather than END.
               if (i_ba) begin
                  if (w_mismatch) begin
                     r_state <= ERR;
                  end else if (i_length1) begin
                     r_state    <= END;
                     r_xfer_end <= 1'b1;
                  end
               end
            end
            END, ERR: begin
               r_state <= IDLE;
               r_dma   <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_dma   <= 1'b0;
            end
         endcase
      end
   end

   assign w_lat_load = (r_state == SW_RD) && i_ba;

   reu_swap_latch u_swap_latch (
      .i_phi2    (i_phi2),
      .i_reset   (i_reset),
      .i_load    (w_lat_load),
      .i_c64_din (i_c64_din),
      .i_ram_din (i_ram_din),
      .o_lat_c   (w_lat_c),
      .o_lat_r   (w_lat_r)
   );

   // Strobes are gated by BA in the same cycle so a stall costs no bus access.
   always_comb begin
      o_c64_rd   = 1'b0;
      o_c64_wr   = 1'b0;
      o_ram_rd   = 1'b0;
      o_ram_wr   = 1'b0;
      o_c64_dout = 8'h00;
      o_ram_dout = 8'h00;
      w_next     = 1'b0;
      if (i_ba) begin
         unique case (r_state)
            STASH: begin
               o_c64_rd   = 1'b1;
               o_ram_wr   = 1'b1;
               o_ram_dout = i_c64_din;
               w_next     = 1'b1;
            end
            FETCH: begin
               o_ram_rd   = 1'b1;
               o_c64_wr   = 1'b1;
               o_c64_dout = i_ram_din;
               w_next     = 1'b1;
            end
            SW_RD: begin
               o_c64_rd = 1'b1;
               o_ram_rd = 1'b1;
            end
            SW_WR: begin
               o_c64_wr   = 1'b1;
               o_ram_wr   = 1'b1;
               o_c64_dout = w_lat_r;
               o_ram_dout = w_lat_c;
               w_next     = 1'b1;
            end
            VERIFY: begin
               o_c64_rd = 1'b1;
               o_ram_rd = 1'b1;
               w_next   = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign o_next_ca   = w_next;
   assign o_next_reua = w_next;
   assign o_dma       = r_dma;
   assign o_xfer_end  = r_xfer_end;

endmodule

// File: tb/tb_reu_xfer_seq.sv
// Scoreboard bench for reu_xfer_seq: a register-file/memory model drives the DUT, a transfer
// model predicts every active output cycle, and a monitor pops and compares them.
module tb_reu_xfer_seq;
   import reu_pkg::*;

   typedef struct packed {
      logic       dma;
      logic       c64_rd;
      logic       c64_wr;
      logic       ram_rd;
      logic       ram_wr;
      logic [7:0] c64_dout;
      logic [7:0] ram_dout;
      logic       next_ca;
      logic       next_reua;
      logic       xfer_end;
      logic       verify_err;
   } rec_t;

   logic       phi2;
   logic       reset;
   logic       execute;
   logic       ff00_decode;
   logic [1:0] xfer_type;
   logic       length1;
   logic       cpu_wr_ff00;
   logic       ba;
   logic [7:0] c64_din;
   logic [7:0] ram_din;
   logic       dma;
   logic       c64_rd;
   logic       c64_wr;
   logic       ram_rd;
   logic       ram_wr;
   logic [7:0] c64_dout;
   logic [7:0] ram_dout;
   logic       next_ca;
   logic       next_reua;
   logic       xfer_end;
   logic       verify_err;

   rec_t       exp_q[$];
   int         checks;
   int         errors;
   logic [7:0] cmem [0:255];
   logic [7:0] rmem [0:255];

   reu_xfer_seq u_dut (
      .i_phi2        (phi2),
      .i_reset       (reset),
      .i_execute     (execute),
      .i_ff00_decode (ff00_decode),
      .i_xfer_type   (xfer_type),
      .i_length1     (length1),
      .i_cpu_wr_ff00 (cpu_wr_ff00),
      .i_ba          (ba),
      .i_c64_din     (c64_din),
      .i_ram_din     (ram_din),
      .o_dma         (dma),
      .o_c64_rd      (c64_rd),
      .o_c64_wr      (c64_wr),
      .o_ram_rd      (ram_rd),
      .o_ram_wr      (ram_wr),
      .o_c64_dout    (c64_dout),
      .o_ram_dout    (ram_dout),
      .o_next_ca     (next_ca),
      .o_next_reua   (next_reua),
      .o_xfer_end    (xfer_end),
      .o_verify_err  (verify_err)
   );

   initial phi2 = 1'b1;
   always #5 phi2 = ~phi2;

   function automatic rec_t outs();
      return {dma, c64_rd, c64_wr, ram_rd, ram_wr, c64_dout, ram_dout,
              next_ca, next_reua, xfer_end, verify_err};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_rec(input logic crd, input logic cwr, input logic rrd, input logic rwr,
                           input logic [7:0] cdo, input logic [7:0] rdo, input logic nxt,
                           input logic xend, input logic verr);
      rec_t r;
      r.dma        = 1'b1;
      r.c64_rd     = crd;
      r.c64_wr     = cwr;
      r.ram_rd     = rrd;
      r.ram_wr     = rwr;
      r.c64_dout   = cdo;
      r.ram_dout   = rdo;
      r.next_ca    = nxt;
      r.next_reua  = nxt;
      r.xfer_end   = xend;
      r.verify_err = verr;
      exp_q.push_back(r);
   endtask

   // Byte-level transfer model; abort_after >= 0 stops after that many bytes with no end pulse.
   task automatic build_model(input logic [1:0] t, input int len, input int abort_after,
                              output int n_next);
      bit stop;
      stop   = 1'b0;
      n_next = 0;
      for (int i = 0; i < len && !stop; i++) begin
         if (abort_after >= 0 && i == abort_after) begin
            stop = 1'b1;
         end else begin
            if (t == XT_STASH) begin
               push_rec(1, 0, 0, 1, 8'h00, cmem[i], 1, 0, 0);
            end else if (t == XT_FETCH) begin
               push_rec(0, 1, 1, 0, rmem[i], 8'h00, 1, 0, 0);
            end else if (t == XT_SWAP) begin
               push_rec(1, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0);
               push_rec(0, 1, 0, 1, rmem[i], cmem[i], 1, 0, 0);
            end else begin
               push_rec(1, 0, 1, 0, 8'h00, 8'h00, 1, 0, 0);
            end
            n_next++;
`ifdef REU_VERIFY_EN
            if (t == XT_VERIFY && cmem[i] != rmem[i]) begin
               push_rec(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1);
               stop = 1'b1;
            end
`endif
         end
      end
      if (!stop && abort_after < 0) push_rec(0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0);
   endtask

   task automatic fill_rand(input logic [1:0] t, input int len);
      int idx;
      for (int i = 0; i < len; i++) begin
         cmem[i] = 8'($urandom);
         rmem[i] = (t == XT_VERIFY) ? cmem[i] : 8'($urandom);
      end
      if (t == XT_VERIFY && $urandom_range(2) == 0) begin
         idx = int'($urandom_range(len - 1));
         rmem[idx] = ~rmem[idx];
      end
   endtask

   // Acts as the register file and both memories around one transfer.
   task automatic run_xfer(input logic [1:0] t, input int len, input bit ff00,
                           input int stall_pct, input int stall_start, input int stall_len,
                           input int abort_after, input bit drop_exec);
      int ca, rem, ncount, cyc, hi, exp_next;
      bit done, swrd, rst_issued;
      build_model(t, len, abort_after, exp_next);
      ca = 0; rem = len; ncount = 0; done = 1'b0; swrd = 1'b0; rst_issued = 1'b0;
      @(negedge phi2); #1;
      execute = 1'b1; ff00_decode = ff00; xfer_type = t; length1 = (rem == 1); ba = 1'b1;
      c64_din = cmem[0]; ram_din = rmem[0];
      if (ff00) begin
         hi = 0;
         repeat (10) begin
            @(negedge phi2); #1;
            @(posedge phi2);
            if (dma) hi++;
         end
         check("ff00_dma_held_low", hi, 0);
         @(negedge phi2); #1;
         cpu_wr_ff00 = 1'b1;
      end
      @(negedge phi2); #1;
      cpu_wr_ff00 = 1'b0;
      @(posedge phi2);
      check("dma_rise", 32'(dma), 1);
      cyc = 0;
      while (!done && cyc < 200 + 8 * len) begin
         if (next_ca) begin
            ca++;
            rem--;
            ncount++;
         end
         swrd = c64_rd && ram_rd && !next_ca;
         if (xfer_end || verify_err || rst_issued) done = 1'b1;
         @(negedge phi2); #1;
         cyc++;
         if (!done) begin
            if (drop_exec && cyc == 2) execute = 1'b0;
            length1 = (rem == 1);
            if (cyc >= stall_start && cyc < stall_start + stall_len) ba = 1'b0;
            else ba = (int'($urandom_range(99)) >= stall_pct);
            if (abort_after >= 0 && !rst_issued && ca == abort_after - 1) begin
               reset      = 1'b1;
               ba         = 1'b1;
               rst_issued = 1'b1;
            end
            // After a swap read the bus data is scrambled: the write-back must use the latches.
            c64_din = swrd ? 8'($urandom) : cmem[ca];
            ram_din = swrd ? 8'($urandom) : rmem[ca];
            @(posedge phi2);
         end
      end
      reset = 1'b0; execute = 1'b0; ff00_decode = 1'b0; ba = 1'b1;
      check("xfer_done", 32'(done), 1);
      if (!done) begin
         reset = 1'b1;
         repeat (2) @(negedge phi2);
         #1;
         exp_q.delete();
         reset = 1'b0;
      end
      @(posedge phi2);
      check("dma_fall", 32'(dma), 0);
      check("idle_quiet", 32'(outs()), 0);
      check("next_ca_count", ncount, exp_next);
      check("queue_drain", exp_q.size(), 0);
   endtask

   // Monitor: every cycle with any strobe or pulse must match the next predicted record.
   initial begin
      rec_t act;
      rec_t e;
      forever begin
         @(posedge phi2);
         act = outs();
         if (act.c64_rd || act.c64_wr || act.ram_rd || act.ram_wr || act.next_ca ||
             act.next_reua || act.xfer_end || act.verify_err) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got %h expected no activity", act);
            end else begin
               e = exp_q.pop_front();
               check("scoreboard", 32'(act), 32'(e));
            end
         end
      end
   end

   initial begin
      logic [1:0] t;
      int         n;
      checks = 0; errors = 0;
      reset = 1'b1; execute = 1'b0; ff00_decode = 1'b0; xfer_type = XT_STASH;
      length1 = 1'b0; cpu_wr_ff00 = 1'b0; ba = 1'b1; c64_din = 8'h00; ram_din = 8'h00;
      repeat (2) @(negedge phi2);
      @(posedge phi2);
      check("reset_state", 32'(outs()), 0);
      @(negedge phi2); #1;
      reset = 1'b0;

      cmem[0] = 8'h11; cmem[1] = 8'h22; cmem[2] = 8'h33;
      rmem[0] = 8'h00; rmem[1] = 8'h00; rmem[2] = 8'h00;
      run_xfer(XT_STASH, 3, 1'b0, 0, 0, 0, -1, 1'b0);

      cmem[0] = 8'hAA; rmem[0] = 8'h55;
      run_xfer(XT_SWAP, 1, 1'b0, 0, 0, 0, -1, 1'b0);

      cmem[0] = 8'h5A; rmem[0] = 8'h5A; cmem[1] = 8'h01; rmem[1] = 8'h02;
      cmem[2] = 8'h10; rmem[2] = 8'h10; cmem[3] = 8'h20; rmem[3] = 8'h20;
      run_xfer(XT_VERIFY, 4, 1'b0, 0, 0, 0, -1, 1'b0);

      fill_rand(XT_FETCH, 2);
      run_xfer(XT_FETCH, 2, 1'b1, 0, 0, 0, -1, 1'b0);

      fill_rand(XT_FETCH, 2);
      run_xfer(XT_FETCH, 2, 1'b0, 0, 2, 3, -1, 1'b0);

      fill_rand(XT_STASH, 3);
      run_xfer(XT_STASH, 3, 1'b0, 0, 0, 0, 2, 1'b0);

      for (int k = 0; k < 30; k++) begin
         t = 2'($urandom);
         n = int'($urandom_range(8, 1));
         fill_rand(t, n);
         run_xfer(t, n, ($urandom_range(4) == 0), 25, 0, 0, -1, 1'($urandom_range(1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
